uart_rx_drain: RTL and testbench

//  Downstream consumer of the UART RX wrapper's 12-bit status FIFO. Pops entries, splits each into a

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sat_counter.sv | 41 ++++
 rtl/uart_rx_drain.sv | 150 +++++++++++++++
 tb/tb_uart_rx_drain.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//  Shared definitions for the UART RX drain path: layout of one RX status
//  FIFO entry, the drain FSM state encoding and a small helper that tells
//  whether an entry carries any error flag.
//  No ports (package).
package uart_pkg;

  // One FIFO entry: [7:0] data, [8] FE, [9] PE, [10] OE, [11] BE.
  localparam int ENTRY_W  = 12;
  localparam int DATA_MSB = 7;
  localparam int FE_BIT   = 8;
  localparam int PE_BIT   = 9;
  localparam int OE_BIT   = 10;
  localparam int BE_BIT   = 11;

  // Drain FSM encoding (2 bits, kept as plain constants for older flows).
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_CAPT = 2'b10;
  localparam logic [1:0] ST_HOLD = 2'b11;

  // Field order mirrors the bit layout above, MSB first.
  typedef struct packed {
    logic       be;
    logic       oe;
    logic       pe;
    logic       fe;
    logic [7:0] data;
  } entry_t;

  // True when any of the four error flags of an entry is set.
  function automatic logic any_err(input entry_t e);
    return e.be | e.oe | e.pe | e.fe;
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// uart_sat_counter
//  Saturating event counter. Counts one per cycle while i_inc is high,
//  sticks at all-ones, and is zeroed by i_clr (clear wins over increment).
//  Ports:
//   i_clk    in  1   clock
//   i_rst_n  in  1   asynchronous active-low reset
//   i_inc    in  1   count one event this cycle
//   i_clr    in  1   synchronous clear, higher priority than i_inc
//   o_cnt    out W   current count
module uart_sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

  logic [W-1:0] r_cnt;

  // Count register: clear first, then increment unless already saturated.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/uart_rx_drain.sv
// uart_rx_drain
//  Pops entries from the UART RX status FIFO, splits each into a data byte
//  and error flags, streams them on a valid/ready interface and keeps
//  saturating per-flag error counters. With DROP_ERRORED=1 errored frames
//  are counted and discarded instead of streamed.
//  Ports:
//   UART_clk      in   1      clock
//   rst_n         in   1      asynchronous active-low reset
//   fifo_empty    in   1      RX FIFO empty flag
//   fifo_rd_en    out  1      RX FIFO pop request (one-cycle pulse)
//   fifo_rd_data  in   12     FIFO entry, valid the cycle after a pop
//   m_valid       out  1      output frame valid
//   m_ready       in   1      downstream accepts frame
//   m_data        out  8      received byte
//   m_err         out  4      {BE,OE,PE,FE} of the frame on m_data
//   cnt_clr       in   1      synchronous clear of all counters
//   fe/pe/oe/be_cnt out CNT_W per-flag error counts (saturating)
//   drop_cnt      out  CNT_W  discarded frames (DROP_ERRORED=1 only)
//   err_irq       out  1      one-cycle pulse per errored entry
module uart_rx_drain
  import uart_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter bit DROP_ERRORED = 1'b0
) (
  input  logic               UART_clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [ENTRY_W-1:0] fifo_rd_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic [3:0]         m_err,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   fe_cnt,
  output logic [CNT_W-1:0]   pe_cnt,
  output logic [CNT_W-1:0]   oe_cnt,
  output logic [CNT_W-1:0]   be_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               err_irq
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_m_valid;
  logic [7:0] r_m_data;
  logic [3:0] r_m_err;
  logic       r_err_irq;

  entry_t     w_entry;
  logic       w_capt;
  logic       w_any_err;
  logic       w_drop;

  assign w_entry   = entry_t'(fifo_rd_data);
  assign w_capt    = (r_state == ST_CAPT);
  assign w_any_err = any_err(w_entry);
  assign w_drop    = w_capt && w_any_err && DROP_ERRORED;

  // The pop is issued combinationally from IDLE so it can never overlap an
  // empty FIFO; only one read is ever outstanding because IDLE is left at once.
  assign fifo_rd_en = (r_state == ST_IDLE) && !fifo_empty;

  // Next-state logic of the drain FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      // One cycle for the FIFO's registered read port.
      ST_WAIT: w_state_nxt = ST_CAPT;
      ST_CAPT: begin
        if (w_drop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      // m_valid is always high in HOLD, so m_ready alone completes the handshake.
      ST_HOLD: begin
        if (m_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered stream / interrupt outputs.
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_m_valid <= 1'b0;
      r_m_data  <= 8'h00;
      r_m_err   <= 4'h0;
      r_err_irq <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_irq <= w_capt && w_any_err;
      if (w_capt && !w_drop) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_entry.data;
        r_m_err   <= {w_entry.be, w_entry.oe, w_entry.pe, w_entry.fe};
      end else if ((r_state == ST_HOLD) && m_ready) begin
        r_m_valid <= 1'b0;
      end else begin
        r_m_valid <= r_m_valid;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_err   = r_m_err;
  assign err_irq = r_err_irq;

  uart_sat_counter #(.W(CNT_W)) u_fe_cnt (
    .i_clk(UART_clk), .i_rst_n(rst_n), .i_inc(w_capt && w_entry.fe),
    .i_clr(cnt_clr), .o_cnt(fe_cnt)
  );

  uart_sat_counter #(.W(CNT_W)) u_pe_cnt (
    .i_clk(UART_clk), .i_rst_n(rst_n), .i_inc(w_capt && w_entry.pe),
    .i_clr(cnt_clr), .o_cnt(pe_cnt)
  );

  uart_sat_counter #(.W(CNT_W)) u_oe_cnt (
    .i_clk(UART_clk), .i_rst_n(rst_n), .i_inc(w_capt && w_entry.oe),
    .i_clr(cnt_clr), .o_cnt(oe_cnt)
  );

  uart_sat_counter #(.W(CNT_W)) u_be_cnt (
    .i_clk(UART_clk), .i_rst_n(rst_n), .i_inc(w_capt && w_entry.be),
    .i_clr(cnt_clr), .o_cnt(be_cnt)
  );

  uart_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .i_clk(UART_clk), .i_rst_n(rst_n), .i_inc(w_drop),
    .i_clr(cnt_clr), .o_cnt(drop_cnt)
  );

endmodule

// File: tb/tb_uart_rx_drain.sv
// tb_uart_rx_drain
//  Directed bench for uart_rx_drain. Instance A streams everything (CNT_W=8),
//  instance B discards errored frames with 2-bit counters. Each instance is
//  fed by a small behavioural FIFO with a one-cycle registered read port.
module tb_uart_rx_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A signals
  logic        empty_a, rd_a, mv_a, mr_a, irq_a, clr_a;
  logic [11:0] rdd_a;
  logic [7:0]  md_a;
  logic [3:0]  me_a;
  logic [7:0]  fe_a, pe_a, oe_a, be_a, dr_a;

  // Instance B signals
  logic        empty_b, rd_b, mv_b, mr_b, irq_b, clr_b;
  logic [11:0] rdd_b;
  logic [7:0]  md_b;
  logic [3:0]  me_b;
  logic [1:0]  fe_b, pe_b, oe_b, be_b, dr_b;

  uart_rx_drain #(.CNT_W(8), .DROP_ERRORED(1'b0)) dut_a (
    .UART_clk(clk), .rst_n(rst_n), .fifo_empty(empty_a), .fifo_rd_en(rd_a),
    .fifo_rd_data(rdd_a), .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a),
    .m_err(me_a), .cnt_clr(clr_a), .fe_cnt(fe_a), .pe_cnt(pe_a),
    .oe_cnt(oe_a), .be_cnt(be_a), .drop_cnt(dr_a), .err_irq(irq_a)
  );

  uart_rx_drain #(.CNT_W(2), .DROP_ERRORED(1'b1)) dut_b (
    .UART_clk(clk), .rst_n(rst_n), .fifo_empty(empty_b), .fifo_rd_en(rd_b),
    .fifo_rd_data(rdd_b), .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b),
    .m_err(me_b), .cnt_clr(clr_b), .fe_cnt(fe_b), .pe_cnt(pe_b),
    .oe_cnt(oe_b), .be_cnt(be_b), .drop_cnt(dr_b), .err_irq(irq_b)
  );

  // Behavioural FIFOs: the initial block writes, the always blocks pop.
  logic [11:0] mem_a [0:63];
  logic [11:0] mem_b [0:63];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  int rd_empty_a = 0, rd_empty_b = 0;

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_a  <= wp_a;
      rdd_a <= 12'h000;
    end else if (rd_a) begin
      if (empty_a) rd_empty_a <= rd_empty_a + 1;
      rdd_a <= mem_a[rp_a[5:0]];
      rp_a  <= rp_a + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_b  <= wp_b;
      rdd_b <= 12'h000;
    end else if (rd_b) begin
      if (empty_b) rd_empty_b <= rd_empty_b + 1;
      rdd_b <= mem_b[rp_b[5:0]];
      rp_b  <= rp_b + 1;
    end
  end

  // Monitors: pop / irq counts, accepted frames, valid/ready stability.
  int n_rd_a = 0, n_irq_a = 0, n_irq_b = 0, stab_a = 0;
  logic        pend_a;
  logic [11:0] pd_a;
  logic [11:0] got_a [$];
  logic [11:0] got_b [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a <= 1'b0;
      pd_a   <= 12'h000;
    end else begin
      if (rd_a) n_rd_a <= n_rd_a + 1;
      if (irq_a) n_irq_a <= n_irq_a + 1;
      if (mv_a && mr_a) got_a.push_back({me_a, md_a});
      if (pend_a && (!mv_a || ({me_a, md_a} != pd_a))) stab_a <= stab_a + 1;
      pend_a <= mv_a && !mr_a;
      pd_a   <= {me_a, md_a};
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (irq_b) n_irq_b <= n_irq_b + 1;
      if (mv_b && mr_b) got_b.push_back({me_b, md_b});
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [11:0] v);
    mem_a[wp_a[5:0]] = v;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [11:0] v);
    mem_b[wp_b[5:0]] = v;
    wp_b = wp_b + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid_a(input string tag);
    int n;
    n = 0;
    while (!mv_a && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, mv_a}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] exp_a [5];
    int base;
    exp_a = '{12'h0A5, 12'h23C, 12'h011, 12'h022, 12'h033};

    rst_n = 1'b0;
    mr_a = 1'b0; mr_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    tick(3);

    // Reset state
    chk("rst_valid_a", {31'd0, mv_a}, 32'd0);
    chk("rst_rd_a", {31'd0, rd_a}, 32'd0);
    chk("rst_data_a", {24'd0, md_a}, 32'd0);
    chk("rst_irq_a", {31'd0, irq_a}, 32'd0);
    chk("rst_cnts_a", {fe_a, pe_a, oe_a, be_a}, 32'd0);
    chk("rst_valid_b", {31'd0, mv_b}, 32'd0);
    chk("rst_drop_b", {30'd0, dr_b}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: clean frame
    mr_a = 1'b1;
    push_a(12'h0A5);
    wait_valid_a("t1_valid");
    chk("t1_data", {24'd0, md_a}, 32'h0A5);
    chk("t1_err", {28'd0, me_a}, 32'd0);
    chk("t1_irq", {31'd0, irq_a}, 32'd0);
    tick(1);
    chk("t1_valid_drop", {31'd0, mv_a}, 32'd0);
    chk("t1_cnts", {fe_a, pe_a, oe_a, be_a}, 32'd0);
    chk("t1_irq_cnt", n_irq_a, 32'd0);
    tick(2);

    // 2: parity-error frame, streamed
    push_a(12'h23C);
    wait_valid_a("t2_valid");
    chk("t2_data", {24'd0, md_a}, 32'h03C);
    chk("t2_err", {28'd0, me_a}, 32'h2);
    chk("t2_pe_cnt", {24'd0, pe_a}, 32'd1);
    chk("t2_other_cnt", {fe_a, oe_a, be_a}, 32'd0);
    chk("t2_irq_hi", {31'd0, irq_a}, 32'd1);
    tick(1);
    chk("t2_irq_lo", {31'd0, irq_a}, 32'd0);
    chk("t2_irq_cnt", n_irq_a, 32'd1);
    tick(2);

    // 3: drop mode, FE frame then clean frame
    mr_b = 1'b1;
    push_b(12'h15A);
    push_b(12'h011);
    tick(20);
    chk("t3_stream_n", got_b.size(), 32'd1);
    chk("t3_stream_0", (got_b.size() > 0) ? {20'd0, got_b[0]} : 32'hDEAD, 32'h011);
    chk("t3_fe_cnt", {30'd0, fe_b}, 32'd1);
    chk("t3_drop_cnt", {30'd0, dr_b}, 32'd1);
    chk("t3_irq_cnt", n_irq_b, 32'd1);

    // 4: back-pressure with three queued entries
    mr_a = 1'b0;
    base = n_rd_a;
    push_a(12'h011);
    push_a(12'h022);
    push_a(12'h033);
    wait_valid_a("t4_valid");
    tick(20);
    chk("t4_single_pop", n_rd_a - base, 32'd1);
    chk("t4_data_held", {24'd0, md_a}, 32'h011);
    chk("t4_valid_held", {31'd0, mv_a}, 32'd1);
    mr_a = 1'b1;
    tick(20);
    chk("t4_frames", got_a.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_order_%0d", i), (i < got_a.size()) ? {20'd0, got_a[i]} : 32'hDEAD,
          {20'd0, exp_a[i]});
    end
    chk("t4_stability", stab_a, 32'd0);

    // 5: saturation of 2-bit counters, then clear racing an increment
    for (int i = 0; i < 5; i++) push_b(12'h800 + 12'(i));
    tick(30);
    chk("t5_be_sat", {30'd0, be_b}, 32'd3);
    chk("t5_drop_sat", {30'd0, dr_b}, 32'd3);
    chk("t5_no_stream", got_b.size(), 32'd1);
    chk("t5_irq_cnt", n_irq_b, 32'd6);
    push_b(12'h8FF);
    tick(2);            // entry is now in CAPT
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    chk("t5_clr_be", {30'd0, be_b}, 32'd0);
    chk("t5_clr_drop", {30'd0, dr_b}, 32'd0);
    chk("t5_clr_fe", {30'd0, fe_b}, 32'd0);
    tick(3);
    chk("t5_clr_stays", {28'd0, be_b, dr_b}, 32'd0);

    // 6: asynchronous reset while waiting on the FIFO read
    push_a(12'h044);
    tick(1);            // FSM now in WAIT
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, mv_a}, 32'd0);
    chk("t6_rd", {31'd0, rd_a}, 32'd0);
    chk("t6_data", {24'd0, md_a}, 32'd0);
    chk("t6_pe_cnt", {24'd0, pe_a}, 32'd0);
    chk("t6_irq", {31'd0, irq_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_rd_a;
    tick(10);
    chk("t6_no_pop", n_rd_a - base, 32'd0);
    chk("t6_no_valid", {31'd0, mv_a}, 32'd0);
    chk("rd_while_empty_a", rd_empty_a, 32'd0);
    chk("rd_while_empty_b", rd_empty_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
